// File: rtl/rptr_empty_status.sv
// Read-domain pointer, empty/almost-empty status, fill level and underflow
// tracking for an asynchronous FIFO. All state lives in the rclk domain.
module rptr_empty_status #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned AE_RESET = 1
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic                rerr_clr,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   rae_thresh,
  output logic                rpop,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rundflow
);

  localparam int unsigned PW = ADDRSIZE + 1;

  // AE_RESET only documents the default threshold; tie it off here.
  logic unused_params;
  assign unused_params = ^32'(AE_RESET);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin;
  logic [PW-1:0] levelnext;

  // Pops are only accepted when the registered empty flag is clear.
  assign rpop  = rinc & ~rempty;
  assign raddr = rbin[ADDRSIZE-1:0];

  // Next read pointer in binary and Gray form.
  always_comb begin
    rbinnext  = rbin + PW'(rpop);
    rgraynext = (rbinnext >> 1) ^ rbinnext;
  end

  // Gray-to-binary decode of the synchronized write pointer.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Entries available once this cycle's pop has been taken.
  always_comb begin
    levelnext = wbin - rbinnext;
  end

  // Pointer and status registers; reset overrides all other inputs.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (levelnext <= rae_thresh);
      rlevel        <= levelnext;
    end
  end

  // Sticky underflow: a pop attempt while empty beats a same-cycle clear.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rundflow <= 1'b0;
    end else if (rinc && rempty) begin
      rundflow <= 1'b1;
    end else if (rerr_clr) begin
      rundflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_empty_status.sv
// Directed bench for rptr_empty_status with a queued expected-value scoreboard.
module tb_rptr_empty_status;

  localparam int unsigned A  = 4;
  localparam int unsigned PW = A + 1;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rinc = 1'b0;
  logic          rerr_clr = 1'b0;
  logic [PW-1:0] rq2_wptr = '0;
  logic [PW-1:0] rae_thresh = 5'd1;
  logic          rpop;
  logic [A-1:0]  raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [PW-1:0] rlevel;
  logic          rundflow;

  rptr_empty_status #(.ADDRSIZE(A), .AE_RESET(1)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rerr_clr(rerr_clr),
    .rq2_wptr(rq2_wptr), .rae_thresh(rae_thresh), .rpop(rpop),
    .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rundflow(rundflow)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic          empty;
    logic          ae;
    logic [PW-1:0] level;
    logic [PW-1:0] ptr;
    logic [A-1:0]  addr;
    logic          und;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int msb_toggles = 0;

  // Reference model state (binary pointers, written side tracked directly).
  logic [PW-1:0] m_rbin = '0;
  logic [PW-1:0] m_wbin = '0;
  logic          m_empty = 1'b1;
  logic          m_und = 1'b0;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, clock, compare against the queued prediction.
  task automatic step(input logic inc, input logic clr, input logic rst,
                      input int wb, input int thr);
    exp_t e, got;
    logic [PW-1:0] prev_ptr;
    logic [PW-1:0] lvl;
    logic          pop;
    rinc       = inc;
    rerr_clr   = clr;
    rrst       = rst;
    m_wbin     = PW'(wb);
    rq2_wptr   = to_gray(m_wbin);
    rae_thresh = PW'(thr);
    #1;
    pop = inc & ~m_empty;
    chk("rpop", 32'(rpop), 32'(pop));
    if (rst) begin
      m_rbin  = '0;
      m_empty = 1'b1;
      m_und   = 1'b0;
      lvl     = '0;
      e.ae    = 1'b1;
    end else begin
      if (inc && m_empty) m_und = 1'b1;
      else if (clr)       m_und = 1'b0;
      m_rbin  = m_rbin + PW'(pop);
      lvl     = m_wbin - m_rbin;
      m_empty = (lvl == '0);
      e.ae    = (32'(lvl) <= 32'(thr));
    end
    e.empty = m_empty;
    e.level = lvl;
    e.ptr   = to_gray(m_rbin);
    e.addr  = m_rbin[A-1:0];
    e.und   = m_und;
    q.push_back(e);
    prev_ptr = rptr;
    @(posedge rclk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'(0), 32'(1));
    end else begin
      got = q.pop_front();
      chk("rempty",        32'(rempty),        32'(got.empty));
      chk("ralmost_empty", 32'(ralmost_empty), 32'(got.ae));
      chk("rlevel",        32'(rlevel),        32'(got.level));
      chk("rptr",          32'(rptr),          32'(got.ptr));
      chk("raddr",         32'(raddr),         32'(got.addr));
      chk("rundflow",      32'(rundflow),      32'(got.und));
      chk("empty_inv",     32'(rempty),        32'(rlevel == '0));
    end
    if (!rst) begin
      chk("gray_1bit", 32'($countones(prev_ptr ^ rptr) <= 1), 32'(1));
      if (prev_ptr[PW-1] != rptr[PW-1]) msb_toggles++;
    end
  endtask

  initial begin
    // Reset, then idle with an empty FIFO.
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t1_rempty", 32'(rempty), 32'(1));
    chk("t1_rlevel", 32'(rlevel), 32'(0));

    // Three entries written, then drained with three pops.
    step(0, 0, 0, 3, 1);
    chk("t2_level3", 32'(rlevel), 32'(3));
    step(1, 0, 0, 3, 1);
    step(1, 0, 0, 3, 1);
    chk("t2_ae_at1", 32'(ralmost_empty), 32'(1));
    step(1, 0, 0, 3, 1);
    chk("t2_rptr", 32'(rptr), 32'(5'b00010));

    // Underflow: ignored pops, clear, then set beating clear.
    step(1, 0, 0, 3, 1);
    step(1, 0, 0, 3, 1);
    chk("t3_raddr_hold", 32'(raddr), 32'(3));
    chk("t3_und_set", 32'(rundflow), 32'(1));
    step(0, 1, 0, 3, 1);
    chk("t3_und_clr", 32'(rundflow), 32'(0));
    step(1, 1, 0, 3, 1);
    chk("t3_set_wins", 32'(rundflow), 32'(1));

    // Wrap-around: full FIFO drained twice, pointer laps back to zero.
    step(0, 0, 1, 0, 1);
    msb_toggles = 0;
    step(0, 0, 0, 16, 1);
    chk("t4_full", 32'(rlevel), 32'(16));
    for (int k = 0; k < 16; k++) step(1, 0, 0, 16, 1);
    chk("t4_rptr_half", 32'(rptr), 32'(5'b11000));
    chk("t4_empty_half", 32'(rempty), 32'(1));
    step(0, 0, 0, 32, 1);
    for (int k = 0; k < 16; k++) step(1, 0, 0, 32, 1);
    chk("t4_rptr_lap", 32'(rptr), 32'(0));
    chk("t4_msb_toggles", 32'(msb_toggles), 32'(2));

    // Simultaneous pop and write advance holds the level at 4.
    step(0, 0, 0, 4, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 5 + k, 1);
      chk("t5_level_hold", 32'(rlevel), 32'(4));
    end

    // Threshold corners: zero tracks empty, >= depth pins almost-empty.
    step(0, 0, 0, 7, 0);
    step(0, 0, 0, 7, 16);
    chk("t5_ae_depth", 32'(ralmost_empty), 32'(1));
    step(0, 0, 0, 7, 31);

    // Mid-stream reset at level 7 with a pop requested.
    step(0, 0, 0, 10, 1);
    chk("t6_level7", 32'(rlevel), 32'(7));
    step(1, 0, 1, 10, 1);
    chk("t6_rst_rptr", 32'(rptr), 32'(0));
    step(0, 0, 0, 10, 1);
    step(1, 0, 0, 10, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
